// File: rtl/mem_arbiter.sv
// Two-way round-robin arbiter sharing one external memory port between I-cache and D-cache refill.
// A granted burst of BURST_LEN beats is never split; mem_req always drops for a cycle between bursts.
module mem_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic [XLEN-1:0] i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic GNT_SIDE_I = 1'b0;
  localparam logic GNT_SIDE_D = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             last_gnt, last_gnt_nxt;

  // State register; reset leaves last_gnt on D so I wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      last_gnt <= GNT_SIDE_D;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  // Next-state and port routing; a dropped request aborts and suppresses that cycle's ack.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    last_gnt_nxt = last_gnt;
    i_ack        = 1'b0;
    i_rdata      = '0;
    d_ack        = 1'b0;
    d_rdata      = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_gnt == GNT_SIDE_D)) begin
          state_nxt = GNT_I;
        end else if (d_req) begin
          state_nxt = GNT_D;
        end
      end

      GNT_I: begin
        mem_req  = i_req;
        mem_addr = i_addr;
        if (!i_req) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
          last_gnt_nxt = GNT_SIDE_I;
        end else begin
          i_ack   = mem_ack;
          i_rdata = mem_rdata;
          if (mem_ack) begin
            if (beat_cnt == LAST_BEAT) begin
              state_nxt    = IDLE;
              beat_cnt_nxt = '0;
              last_gnt_nxt = GNT_SIDE_I;
            end else begin
              beat_cnt_nxt = beat_cnt + CNT_W'(1);
            end
          end
        end
      end

      GNT_D: begin
        mem_req   = d_req;
        mem_we    = d_req & d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        if (!d_req) begin
          state_nxt    = IDLE;
          beat_cnt_nxt = '0;
          last_gnt_nxt = GNT_SIDE_D;
        end else begin
          d_ack   = mem_ack;
          d_rdata = mem_rdata;
          if (mem_ack) begin
            if (beat_cnt == LAST_BEAT) begin
              state_nxt    = IDLE;
              beat_cnt_nxt = '0;
              last_gnt_nxt = GNT_SIDE_D;
            end else begin
              beat_cnt_nxt = beat_cnt + CNT_W'(1);
            end
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single bursts, round-robin ties, writeback, abort, reset and idle acks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_ack, d_ack, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.XLEN(32), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n acked beats to the granted side; entered and left at posedge+1.
  task automatic burst(input logic is_d, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      if (is_d) d_addr = base + 32'(4 * k);
      else      i_addr = base + 32'(4 * k);
      mem_ack   = 1'b1;
      mem_rdata = 32'hA0 + 32'(k);
      #1;
      check("beat_mem_req",  32'(mem_req), 32'd1);
      check("beat_mem_addr", mem_addr, base + 32'(4 * k));
      check("beat_i_ack",    32'(i_ack), 32'(!is_d));
      check("beat_d_ack",    32'(d_ack), 32'(is_d));
      check("beat_rdata",    is_d ? d_rdata : i_rdata, 32'hA0 + 32'(k));
      check("beat_other_rdata", is_d ? i_rdata : d_rdata, 32'd0);
      check("beat_mem_we",   32'(mem_we), 32'(is_d & d_we));
      check("beat_mem_wdata", mem_wdata, is_d ? d_wdata : 32'd0);
      tick();
    end
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    tick();
    check("rst_mem_req",  32'(mem_req), 32'd0);
    check("rst_acks",     32'({i_ack, d_ack}), 32'd0);
    check("rst_state",    32'(dut.state), 32'd0);
    check("rst_beat_cnt", 32'(dut.beat_cnt), 32'd0);
    check("rst_last_gnt", 32'(dut.last_gnt), 32'd1);
    reset = 1'b0;
    tick();

    // 1: lone I burst; mem_req waits one cycle for the registered grant
    i_req = 1; i_addr = 32'h100;
    #1;
    check("t1_req_delay", 32'(mem_req), 32'd0);
    tick();
    burst(1'b0, 32'h100, 4);
    i_req = 0;
    #1;
    check("t1_idle_state", 32'(dut.state), 32'd0);
    check("t1_idle_req",   32'(mem_req), 32'd0);
    check("t1_last_gnt",   32'(dut.last_gnt), 32'd0);

    // 2: simultaneous requests after reset -> I, idle gap, D, then I again
    reset = 1; #1; reset = 0;
    i_req = 1; d_req = 1; d_we = 0;
    tick();
    check("t2_first_i", 32'(dut.state), 32'd1);
    burst(1'b0, 32'h300, 4);
    i_req = 0;
    #1;
    check("t2_gap_req", 32'(mem_req), 32'd0);
    tick();
    check("t2_then_d", 32'(dut.state), 32'd2);
    burst(1'b1, 32'h400, 4);
    i_req = 1;
    #1;
    check("t2_gap2_req", 32'(mem_req), 32'd0);
    tick();
    check("t2_repeat_i", 32'(dut.state), 32'd1);
    burst(1'b0, 32'h500, 4);
    tick();
    check("t2_repeat_d", 32'(dut.state), 32'd2);
    burst(1'b1, 32'h600, 4);
    i_req = 0; d_req = 0;
    tick();

    // 3: D writeback; I request raised mid-burst must wait
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
    tick();
    check("t3_gnt_d", 32'(dut.state), 32'd2);
    i_req = 1; i_addr = 32'h900;
    burst(1'b1, 32'h2000, 4);
    d_req = 0; d_we = 0;
    #1;
    check("t3_wait_iack", 32'(i_ack), 32'd0);
    tick();
    check("t3_i_served", 32'(dut.state), 32'd1);

    // 4: I aborts after two beats while D waits; the drop-cycle ack is swallowed
    d_req = 1;
    burst(1'b0, 32'h700, 2);
    check("t4_cnt_mid", 32'(dut.beat_cnt), 32'd2);
    i_req = 0; mem_ack = 1;
    #1;
    check("t4_drop_iack", 32'(i_ack), 32'd0);
    check("t4_drop_req",  32'(mem_req), 32'd0);
    tick();
    mem_ack = 0;
    #1;
    check("t4_idle",     32'(dut.state), 32'd0);
    check("t4_cnt_zero", 32'(dut.beat_cnt), 32'd0);
    tick();
    check("t4_gnt_d",    32'(dut.state), 32'd2);
    check("t4_d_memreq", 32'(mem_req), 32'd1);

    // 5: reset during beat 3 of a D write burst
    d_we = 1;
    burst(1'b1, 32'h800, 2);
    mem_ack = 1;
    #1;
    check("t5_pre_dack", 32'(d_ack), 32'd1);
    reset = 1;
    #1;
    check("t5_rst_req",  32'(mem_req), 32'd0);
    check("t5_rst_dack", 32'(d_ack), 32'd0);
    check("t5_rst_we",   32'(mem_we), 32'd0);
    mem_ack = 0; d_we = 0;
    tick();
    reset = 0; i_req = 1; d_req = 1;
    tick();
    check("t5_i_wins", 32'(dut.state), 32'd1);
    i_req = 0; d_req = 0;
    tick();
    check("t5_abort_idle", 32'(dut.state), 32'd0);

    // 6: stray ack in IDLE
    mem_ack = 1; mem_rdata = 32'h55;
    #1;
    check("t6_acks", 32'({i_ack, d_ack}), 32'd0);
    tick();
    mem_ack = 0;
    #1;
    check("t6_cnt",   32'(dut.beat_cnt), 32'd0);
    check("t6_state", 32'(dut.state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
